div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 24 ++
 rtl/div_unit.sv | 194 +++++++++++++++++++
 tb/tb_div_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types for the iterative divider.
// Result fields are sized for the widest legal WIDTH.
package div_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  typedef struct packed {
    logic [MAX_W-1:0] quotient;
    logic [MAX_W-1:0] remainder;
    logic             error;
  } div_res_t;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 division iteration.
// Shifts in a dividend bit, subtracts if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] den,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, den};

  // a clear top bit means no borrow: the divisor fits
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0]
                         : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative signed/unsigned divider, one bit per cycle.
// DIV_EARLY_OUT_EN: divide-by-zero and overflow skip the iterations.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] nume,
  input  logic [WIDTH-1:0] den,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  div_state_t       state;
  div_state_t       state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] qs;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] dm;
  logic [WIDTH-1:0] nr;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             ovf;
  div_res_t         res;

  logic             accept;
  logic             early;
  logic             n_neg;
  logic             d_neg;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;
  logic             dz_in;
  logic             ovf_in;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // upper result bits beyond WIDTH are intentionally unread
  logic [$bits(div_res_t)-1:0] res_unused;
  assign res_unused = res;

  function automatic div_res_t fix_res(
    input logic             f_dz,
    input logic             f_ovf,
    input logic [WIDTH-1:0] f_n,
    input logic [WIDTH-1:0] f_q,
    input logic [WIDTH-1:0] f_r
  );
    div_res_t o;
    o = '0;
    if (f_dz) begin
      o.quotient  = MAX_W'(ONES);
      o.remainder = MAX_W'(f_n);
      o.error     = 1'b1;
    end else if (f_ovf) begin
      o.quotient  = MAX_W'(f_n);
    end else begin
      o.quotient  = MAX_W'(f_q);
      o.remainder = MAX_W'(f_r);
    end
    return o;
  endfunction

  assign accept = in_valid && in_ready;
  assign n_neg  = is_signed && nume[WIDTH-1];
  assign d_neg  = is_signed && den[WIDTH-1];
  assign n_mag  = n_neg ? -nume : nume;
  assign d_mag  = d_neg ? -den : den;
  assign dz_in  = (den == '0);
  assign ovf_in = is_signed
               && (nume == MIN_V)
               && (den == ONES);

`ifdef DIV_EARLY_OUT_EN
  assign early = dz_in || ovf_in;
`else
  assign early = 1'b0;
`endif

  assign q_fix = neg_q ? -qs : qs;
  assign r_fix = neg_r ? -rs : rs;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rs),
    .den     (dm),
    .bit_in  (qs[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = res.quotient[WIDTH-1:0];
  assign remainder = res.remainder[WIDTH-1:0];
  assign error     = res.error;

  // state register, clr wins over any handshake
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = early ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // operand capture, iteration and sign fix-up
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt   <= '0;
      qs    <= '0;
      rs    <= '0;
      dm    <= '0;
      nr    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      res   <= '0;
    end else begin
      if (accept) begin
        cnt   <= CNT_W'(WIDTH);
        qs    <= n_mag;
        rs    <= '0;
        dm    <= d_mag;
        nr    <= nume;
        neg_q <= n_neg ^ d_neg;
        neg_r <= n_neg;
        dz    <= dz_in;
        ovf   <= ovf_in;
        if (early) begin
          res <= fix_res(dz_in, ovf_in, nume,
                         '0, '0);
        end
      end
      if (state == CALC) begin
        cnt <= cnt - CNT_W'(1);
        qs  <= {qs[WIDTH-2:0], step_q};
        rs  <= step_rem;
      end
      if (state == FIX) begin
        res <= fix_res(dz, ovf, nr,
                       q_fix, r_fix);
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit (WIDTH 32 and 16).
// Expected results are queued at issue, popped at handoff.
module tb_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] nume;
  logic [31:0] den;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        error;
  logic        busy;

  logic        h_clr;
  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_nume;
  logic [15:0] h_den;
  logic        h_is_signed;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [15:0] h_quotient;
  logic [15:0] h_remainder;
  logic        h_error;
  logic        h_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  div_unit #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .nume      (nume),
    .den       (den),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .error     (error),
    .busy      (busy)
  );

  div_unit #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .clr       (h_clr),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .nume      (h_nume),
    .den       (h_den),
    .is_signed (h_is_signed),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .quotient  (h_quotient),
    .remainder (h_remainder),
    .error     (h_error),
    .busy      (h_busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [31:0] n,
    input logic [31:0] d,
    input logic        s
  );
    exp_t e;
    logic signed [31:0] sn;
    logic signed [31:0] sd;
    logic sp;
    sn = n;
    sd = d;
    sp = (d == 0) ||
         (s && n == 32'h8000_0000 &&
          d == 32'hFFFF_FFFF);
    e.e = (d == 0);
    if (d == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = n;
    end else if (sp) begin
      e.q = n;
      e.r = 32'd0;
    end else if (s) begin
      e.q = sn / sd;
      e.r = sn % sd;
    end else begin
      e.q = n / d;
      e.r = n % d;
    end
`ifdef DIV_EARLY_OUT_EN
    e.lat = sp ? 1 : 34;
`else
    e.lat = 34;
`endif
    return e;
  endfunction

  task automatic issue(input logic [31:0] n,
                       input logic [31:0] d,
                       input logic        s);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("issue_to", 0, 1);
    nume      = n;
    den       = d;
    is_signed = s;
    in_valid  = 1'b1;
    sbq.push_back(model(n, d, s));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    nume      = $urandom;
    den       = $urandom;
    is_signed = 1'($urandom);
  endtask

  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk("lat", lat, e.lat);
    chk("quot", quotient, e.q);
    chk("rem", remainder, e.r);
    chk("err", error, e.e);
    chk("rdy_done", in_ready, 0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_v", out_valid, 1);
      chk("hold_q", quotient, e.q);
      chk("hold_r", remainder, e.r);
      chk("hold_e", error, e.e);
      chk("hold_rdy", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk("rdy_hs", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("cons_v", out_valid, 0);
    chk("cons_busy", busy, 0);
    chk("cons_rdy", in_ready, 1);
  endtask

  task automatic op(input logic [31:0] n,
                    input logic [31:0] d,
                    input logic        s,
                    input int          hold);
    issue(n, d, s);
    collect(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic [31:0] rn;
    logic [31:0] rd;
    clr         = 1'b1;
    in_valid    = 1'b0;
    nume        = '0;
    den         = '0;
    is_signed   = 1'b0;
    out_ready   = 1'b0;
    h_clr       = 1'b1;
    h_in_valid  = 1'b0;
    h_nume      = '0;
    h_den       = '0;
    h_is_signed = 1'b0;
    h_out_ready = 1'b0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    in_valid = 1'b1;
    nume     = 32'd5;
    den      = 32'd1;
    @(posedge clk);
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_v", out_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    clr      = 1'b0;
    in_valid = 1'b0;
    h_clr    = 1'b0;

    op(32'd100, 32'd10, 1'b0, 0);
    op(-32'sd7, 32'd2, 1'b1, 0);
    op(32'd999, 32'd0, 1'b0, 0);
    op(32'd999, 32'd0, 1'b1, 1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    op(32'd5000, 32'd3, 1'b0, 5);
    op(32'd3, 32'd7, 1'b0, 0);
    op(32'd7, -32'sd2, 1'b1, 0);
    op(-32'sd8, -32'sd3, 1'b1, 2);
    op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    op(32'hFFFF_FFFF, 32'd1, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      rn = $urandom;
      rd = $urandom >> $urandom_range(0, 31);
      op(rn, rd, 1'($urandom), i % 3);
    end

    issue(32'd1234, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    void'(sbq.pop_back());
    chk("clr32_rdy", in_ready, 1);
    chk("clr32_busy", busy, 0);

    @(negedge clk);
    h_nume     = 16'd1000;
    h_den      = 16'd7;
    h_in_valid = 1'b1;
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    h_nume     = 16'hBEEF;
    h_den      = 16'h0003;
    chk("h_acc_busy", h_busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    h_clr = 1'b1;
    @(posedge clk);
    #1;
    h_clr = 1'b0;
    chk("h_clr_rdy", h_in_ready, 1);
    chk("h_clr_busy", h_busy, 0);
    chk("h_clr_v", h_out_valid, 0);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (h_out_valid) seen = 1;
    end
    chk("h_no_valid", seen, 0);

    @(negedge clk);
    h_nume     = 16'd33;
    h_den      = 16'd4;
    h_in_valid = 1'b1;
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    h_nume     = 16'h1234;
    h_den      = 16'h0001;
    lat = 1;
    while (!h_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("h_lat", lat, 18);
    chk("h_q", h_quotient, 16'd8);
    chk("h_r", h_remainder, 16'd1);
    chk("h_err", h_error, 0);
    @(negedge clk);
    h_out_ready = 1'b1;
    @(posedge clk);
    #1;
    h_out_ready = 1'b0;
    chk("h_cons_v", h_out_valid, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
